// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared VGA timing constants and the timing-mode struct.
//  Revision    : 1.0 - initial parametrised timing release
// ============================================================================
package vga_pkg;

    localparam int unsigned C_TIMING_W = 11;

    localparam logic [C_TIMING_W-1:0] c_h_active_1024     = 11'd1024;
    localparam logic [C_TIMING_W-1:0] c_h_sync_start_1024 = 11'd1048;
    localparam logic [C_TIMING_W-1:0] c_h_sync_stop_1024  = 11'd1184;
    localparam logic [C_TIMING_W-1:0] c_h_total_1024      = 11'd1344;
    localparam logic [C_TIMING_W-1:0] c_v_active_768      = 11'd768;
    localparam logic [C_TIMING_W-1:0] c_v_sync_start_768  = 11'd771;
    localparam logic [C_TIMING_W-1:0] c_v_sync_stop_768   = 11'd777;
    localparam logic [C_TIMING_W-1:0] c_v_total_768       = 11'd806;

    localparam logic [C_TIMING_W-1:0] c_h_active_800      = 11'd800;
    localparam logic [C_TIMING_W-1:0] c_h_sync_start_800  = 11'd840;
    localparam logic [C_TIMING_W-1:0] c_h_sync_stop_800   = 11'd968;
    localparam logic [C_TIMING_W-1:0] c_h_total_800       = 11'd1056;
    localparam logic [C_TIMING_W-1:0] c_v_active_600      = 11'd600;
    localparam logic [C_TIMING_W-1:0] c_v_sync_start_600  = 11'd601;
    localparam logic [C_TIMING_W-1:0] c_v_sync_stop_600   = 11'd605;
    localparam logic [C_TIMING_W-1:0] c_v_total_600       = 11'd628;

    typedef struct packed {
        logic [C_TIMING_W-1:0] h_active;
        logic [C_TIMING_W-1:0] h_sync_start;
        logic [C_TIMING_W-1:0] h_sync_stop;
        logic [C_TIMING_W-1:0] h_total;
        logic [C_TIMING_W-1:0] v_active;
        logic [C_TIMING_W-1:0] v_sync_start;
        logic [C_TIMING_W-1:0] v_sync_stop;
        logic [C_TIMING_W-1:0] v_total;
    } vga_timing_t;

    localparam vga_timing_t TIMING_1024X768 = '{
        h_active:     c_h_active_1024,
        h_sync_start: c_h_sync_start_1024,
        h_sync_stop:  c_h_sync_stop_1024,
        h_total:      c_h_total_1024,
        v_active:     c_v_active_768,
        v_sync_start: c_v_sync_start_768,
        v_sync_stop:  c_v_sync_stop_768,
        v_total:      c_v_total_768
    };

    localparam vga_timing_t TIMING_800X600 = '{
        h_active:     c_h_active_800,
        h_sync_start: c_h_sync_start_800,
        h_sync_stop:  c_h_sync_stop_800,
        h_total:      c_h_total_800,
        v_active:     c_v_active_600,
        v_sync_start: c_v_sync_start_600,
        v_sync_stop:  c_v_sync_stop_600,
        v_total:      c_v_total_600
    };

endpackage
`default_nettype wire

// File: rtl/vga_sync_decode.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_decode
//  Description : Combinational sync/blank/strobe decode of the next counts.
//  Revision    : 1.0 - initial parametrised timing release
// ============================================================================
module vga_sync_decode
    import vga_pkg::*;
#(
    parameter int   CNT_W     = 11,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic [CNT_W-1:0] i_hcount_nxt,
    input  logic [CNT_W-1:0] i_vcount_nxt,
    input  vga_timing_t      i_timing,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_hblnk,
    output logic             o_vblnk,
    output logic             o_line_start,
    output logic             o_frame_start
);

    logic [CNT_W-1:0] w_h_active;
    logic [CNT_W-1:0] w_h_sync_start;
    logic [CNT_W-1:0] w_h_sync_stop;
    logic [CNT_W-1:0] w_v_active;
    logic [CNT_W-1:0] w_v_sync_start;
    logic [CNT_W-1:0] w_v_sync_stop;
    logic             w_h_in_sync;
    logic             w_v_in_sync;

    assign w_h_active     = CNT_W'(i_timing.h_active);
    assign w_h_sync_start = CNT_W'(i_timing.h_sync_start);
    assign w_h_sync_stop  = CNT_W'(i_timing.h_sync_stop);
    assign w_v_active     = CNT_W'(i_timing.v_active);
    assign w_v_sync_start = CNT_W'(i_timing.v_sync_start);
    assign w_v_sync_stop  = CNT_W'(i_timing.v_sync_stop);

    assign w_h_in_sync = (i_hcount_nxt >= w_h_sync_start) && (i_hcount_nxt < w_h_sync_stop);
    assign w_v_in_sync = (i_vcount_nxt >= w_v_sync_start) && (i_vcount_nxt < w_v_sync_stop);

    assign o_hsync       = w_h_in_sync ? HSYNC_POL : ~HSYNC_POL;
    assign o_vsync       = w_v_in_sync ? VSYNC_POL : ~VSYNC_POL;
    assign o_hblnk       = (i_hcount_nxt >= w_h_active);
    assign o_vblnk       = (i_vcount_nxt >= w_v_active);
    assign o_line_start  = (i_hcount_nxt == '0);
    assign o_frame_start = (i_hcount_nxt == '0) && (i_vcount_nxt == '0);

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Two-mode VGA timing generator with stall, strobes and frame count.
//  Revision    : 1.0 - initial parametrised timing release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int          CNT_W     = 11,
    parameter int          FRAME_W   = 16,
    parameter vga_timing_t MODE0     = TIMING_1024X768,
    parameter vga_timing_t MODE1     = TIMING_800X600,
    parameter logic        HSYNC_POL = 1'b0,
    parameter logic        VSYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode_sel,
    output logic [CNT_W-1:0]   hcount,
    output logic [CNT_W-1:0]   vcount,
    output logic               hsync,
    output logic               vsync,
    output logic               hblnk,
    output logic               vblnk,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               mode_active
);

    if ((int'(MODE0.h_total) > (1 << CNT_W)) || (int'(MODE0.v_total) > (1 << CNT_W)) ||
        (int'(MODE1.h_total) > (1 << CNT_W)) || (int'(MODE1.v_total) > (1 << CNT_W)))
    begin : g_cnt_w_check
        $error("vga_timing_gen: CNT_W too small for configured timing totals");
    end

    logic [CNT_W-1:0]   r_hcount;
    logic [CNT_W-1:0]   r_vcount;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_hblnk;
    logic               r_vblnk;
    logic               r_line_start;
    logic               r_frame_start;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic               r_mode;

    vga_timing_t        w_timing;
    vga_timing_t        w_timing_nxt;
    logic [CNT_W-1:0]   w_h_max;
    logic [CNT_W-1:0]   w_v_max;
    logic               w_h_last;
    logic               w_v_last;
    logic               w_frame_wrap;
    logic               w_mode_nxt;
    logic [CNT_W-1:0]   w_hcount_nxt;
    logic [CNT_W-1:0]   w_vcount_nxt;
    logic               w_hsync_nxt;
    logic               w_vsync_nxt;
    logic               w_hblnk_nxt;
    logic               w_vblnk_nxt;
    logic               w_line_start_nxt;
    logic               w_frame_start_nxt;

    always_comb begin
        w_timing     = r_mode ? MODE1 : MODE0;
        w_h_max      = CNT_W'(w_timing.h_total - 11'd1);
        w_v_max      = CNT_W'(w_timing.v_total - 11'd1);
        w_h_last     = (r_hcount == w_h_max);
        w_v_last     = (r_vcount == w_v_max);
        w_frame_wrap = w_h_last && w_v_last;
        // Mode can only change on the frame wrap, so counters never exceed the new totals.
        w_mode_nxt   = w_frame_wrap ? mode_sel : r_mode;
        w_timing_nxt = w_mode_nxt ? MODE1 : MODE0;
        w_hcount_nxt = w_h_last ? '0 : (r_hcount + CNT_W'(1));
        w_vcount_nxt = r_vcount;
        if (w_h_last) begin
            w_vcount_nxt = w_v_last ? '0 : (r_vcount + CNT_W'(1));
        end
    end

    vga_sync_decode #(
        .CNT_W     (CNT_W),
        .HSYNC_POL (HSYNC_POL),
        .VSYNC_POL (VSYNC_POL)
    ) u_sync_decode (
        .i_hcount_nxt  (w_hcount_nxt),
        .i_vcount_nxt  (w_vcount_nxt),
        .i_timing      (w_timing_nxt),
        .o_hsync       (w_hsync_nxt),
        .o_vsync       (w_vsync_nxt),
        .o_hblnk       (w_hblnk_nxt),
        .o_vblnk       (w_vblnk_nxt),
        .o_line_start  (w_line_start_nxt),
        .o_frame_start (w_frame_start_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
            r_mode        <= 1'b0;
        end else if (en) begin
            r_hcount      <= w_hcount_nxt;
            r_vcount      <= w_vcount_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_hblnk       <= w_hblnk_nxt;
            r_vblnk       <= w_vblnk_nxt;
            r_line_start  <= w_line_start_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_mode        <= w_mode_nxt;
            if (w_frame_start_nxt) begin
                r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
            end
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign hblnk       = r_hblnk;
    assign vblnk       = r_vblnk;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;
    assign mode_active = r_mode;

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator; successor to the fixed 1024x768 timing.
- Supports two run-time-selectable timing modes (struct parameters), configurable sync polarity, an enable/stall input, and frame/line start strobes plus a frame counter.
- Sits at the head of the video pipeline and drives hcount/vcount/sync/blank into the draw stages (background, rect, terrain, player).

Parameters:
- CNT_W, 11, width of hcount/vcount; must hold max h_total-1 and v_total-1.
- FRAME_W, 16, width of frame counter.
- MODE0, vga_pkg::TIMING_1024X768, timing struct for mode_sel=0 (1024/1048/1184/1344, 768/771/777/806).
- MODE1, vga_pkg::TIMING_800X600, timing struct for mode_sel=1 (800/840/968/1056, 600/601/605/628).
- HSYNC_POL, 1'b0, asserted level of hsync.
- VSYNC_POL, 1'b0, asserted level of vsync.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  count enable; low = stall, all outputs hold.
- mode_sel  in  1  requested mode, sampled only at frame end.
- hcount  out  CNT_W  horizontal pixel position.
- vcount  out  CNT_W  vertical line position.
- hsync  out  1  horizontal sync, polarity per HSYNC_POL.
- vsync  out  1  vertical sync, polarity per VSYNC_POL.
- hblnk  out  1  high when hcount >= h_active.
- vblnk  out  1  high when vcount >= v_active.
- line_start  out  1  one-cycle strobe when hcount==0.
- frame_start  out  1  one-cycle strobe when hcount==0 && vcount==0.
- frame_cnt  out  FRAME_W  completed frames, wraps modulo 2^FRAME_W.
- mode_active  out  1  mode currently in effect.

Behaviour:
- Reset (async, rst_n=0), all outputs:
  - hcount=0, vcount=0, hblnk=0, vblnk=0.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL.
  - line_start=0, frame_start=0, frame_cnt=0, mode_active=0 (MODE0).
- Reset asserted mid-frame: immediate return to these values; no partial-frame strobe.
- All outputs registered.
- Sync/blank/strobes are decoded from the next counter values, so every output is consistent with hcount/vcount in the same cycle (zero skew).
- Active timing T is MODE0 or MODE1 per mode_active.
- Counting when en=1:
  - hcount increments; at hcount==T.h_total-1 it wraps to 0 and vcount increments.
  - vcount wraps to 0 after T.v_total-1.
- First cycle after reset release with en=1: hcount=1, vcount=0. The (0,0) state is produced by reset, not strobed.
- Strobes:
  - line_start=1 on each cycle where hcount becomes 0.
  - frame_start=1 on each cycle where (hcount,vcount) becomes (0,0).
  - Strobes are single-cycle even if en drops on the next cycle (strobe clears, counters hold).
- en=0: counters, sync and blank hold; line_start/frame_start forced 0.
- Sync decode: hsync asserted iff T.h_sync_start <= hcount < T.h_sync_stop; vsync likewise on vcount.
- Mode switch:
  - mode_sel is sampled only on the wrap from (h_total-1, v_total-1) to (0,0).
  - mode_active updates in that same cycle, so the new frame starts entirely in the new mode.
  - mode_sel changes mid-frame have no effect until frame end.
- frame_cnt increments on every frame_start; wraps 2^FRAME_W-1 -> 0.
- Comparisons are unsigned, CNT_W wide.
- Counter at or beyond h_total (e.g. after a mode change) is impossible by construction, because mode only changes at (0,0).
- Elaboration error if either mode's h_total or v_total > 2^CNT_W.

Decomposition:
- Add to vga_pkg:
  - typedef struct packed vga_timing_t {h_active, h_sync_start, h_sync_stop, h_total, v_active, v_sync_start, v_sync_stop, v_total}, each 11 bits.
  - localparams TIMING_1024X768 and TIMING_800X600, built from the existing constants.
- One sub-module: vga_sync_decode. Combinational; takes the next counts and the timing struct, returns sync/blank/strobe next-values. Instantiated once.

Test Plan:
- Reset, then en=1, MODE0 for 1344*806 cycles -> hsync low for hcount 1048..1183, vblnk high for vcount 768..805. frame_start pulses once, at cycle 1344*806-1; frame_cnt=1.
- Mid-line en toggling (en=0 for 5 cycles at hcount=500) -> hcount holds 500, no strobes, resumes at 501; frame length is 1344*806+5 cycles.
- mode_sel=1 asserted at vcount=300 -> mode_active stays 0 until the wrap. Next frame: h_total=1056, hsync low for 840..967, v_total=628.
- HSYNC_POL=1, VSYNC_POL=1 build -> after reset hsync=0, vsync=0; hsync=1 for hcount 1048..1183.
- rst_n pulsed low at hcount=700, vcount=400 -> outputs return to reset values immediately; frame_cnt=0; mode_active=0.
- FRAME_W=2, 5 frames -> frame_cnt sequence 1,2,3,0,1.
